// File: rtl/uart_pkg.sv
// Shared UART definitions used by uart_rx, uart_tx and the baud generator.
//   UART_OVERSAMPLE : default baud ticks per bit period
//   UART_DATA_BITS  : default data bits per frame
//   uart_state_e    : receiver/transmitter frame state encoding
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE = 16;
    localparam int unsigned UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Multi-stage bit synchronizer for an asynchronous input; flops reset to 1.
//   clk, reset : system clock, asynchronous active-high reset
//   d          : asynchronous input
//   q          : synchronized output (last stage)
module uart_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // Shift the raw input in at the bottom of the chain.
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver with oversampled mid-bit sampling.
//   clk, reset    : system clock, asynchronous active-high reset
//   iRX_BAUD_tick : one-clk enable, OVERSAMPLE pulses per bit period
//   iRX_DATA      : asynchronous serial line, idle high
//   oRX_DATA      : last good received byte
//   oRX_VALID     : one-clk pulse when oRX_DATA is updated
//   oFRAME_ERR    : one-clk pulse when the stop bit is sampled low
//   oBUSY         : high whenever the receiver is not idle
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int unsigned DATA_BITS   = UART_DATA_BITS,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iRX_BAUD_tick,
    input  logic                 iRX_DATA,
    output logic [DATA_BITS-1:0] oRX_DATA,
    output logic                 oRX_VALID,
    output logic                 oFRAME_ERR,
    output logic                 oBUSY
);

    localparam int unsigned TICK_W = $clog2(OVERSAMPLE);
    localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

    logic rxs;

    uart_state_e          state_q,    state_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q,  bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q,    shift_d;
    logic [DATA_BITS-1:0] data_q,     data_d;
    logic                 valid_q,    valid_d;
    logic                 ferr_q,     ferr_d;
    logic                 busy_q,     busy_d;

    uart_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (iRX_DATA),
        .q     (rxs)
    );

    // Frame recovery; everything advances only on baud ticks.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;

        if (iRX_BAUD_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rxs) begin
                        state_d    = ST_START;
                        tick_cnt_d = '0;
                    end
                end
                ST_START: begin
                    // Half a bit after the edge: confirm a real start bit.
                    if (tick_cnt_q == TICK_W'(OVERSAMPLE/2 - 1)) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rxs ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                ST_DATA: begin
                    if (tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) begin
                        // LSB arrives first, so shift right from the top.
                        shift_d    = {rxs, shift_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
                        if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                ST_STOP: begin
                    if (tick_cnt_q == TICK_W'(OVERSAMPLE - 1)) begin
                        tick_cnt_d = '0;
                        if (rxs) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                ST_BREAK: begin
                    // Wait for the line to recover before hunting for a start edge.
                    if (rxs) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            busy_q     <= busy_d;
        end
    end

    assign oRX_DATA   = data_q;
    assign oRX_VALID  = valid_q;
    assign oFRAME_ERR = ferr_q;
    assign oBUSY      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frame driver pushes expected strobes, monitor pops them.
module tb_uart_rx;

    localparam int unsigned OS = 16;

    logic       clk     = 1'b0;
    logic       reset   = 1'b1;
    logic       tick    = 1'b0;
    logic       rxd     = 1'b1;
    logic       tick_en = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       ferr;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] last_good = 8'h00;
    logic       prev_strobe = 1'b0;

    uart_rx #(
        .OVERSAMPLE  (16),
        .DATA_BITS   (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .iRX_BAUD_tick (tick),
        .iRX_DATA      (rxd),
        .oRX_DATA      (rx_data),
        .oRX_VALID     (rx_valid),
        .oFRAME_ERR    (frame_err),
        .oBUSY         (busy)
    );

    always #5 clk = ~clk;

    // One tick every 4 clocks, changed on the falling edge.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            cnt  = (cnt + 1) % 4;
            tick = tick_en && (cnt == 0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && (rx_valid || frame_err)) begin
            check("single strobe", 32'(rx_valid & frame_err), 32'd0);
            check("pulse width", 32'(prev_strobe), 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected strobe: valid=%0b ferr=%0b data=%0h", rx_valid, frame_err, rx_data);
            end else begin
                e = exp_q.pop_front();
                check("strobe kind ferr", 32'(frame_err), 32'(e.ferr));
                check("rx data", 32'(rx_data), 32'(e.data));
            end
        end
        prev_strobe = rx_valid | frame_err;
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
        #1;
    endtask

    task automatic send_bit(input logic b, input int n);
        rxd = b;
        wait_ticks(n);
    endtask

    // hook: 0 plain, 1 reset during data bit 4 (frame aborted), 2 tick pause in data bit 3
    task automatic send_frame(input logic [7:0] d, input logic stop, input int hook);
        logic [7:0] snap;
        if (hook != 1) begin
            if (stop) begin
                exp_q.push_back('{ferr: 1'b0, data: d});
                last_good = d;
            end else begin
                exp_q.push_back('{ferr: 1'b1, data: last_good});
            end
        end
        send_bit(1'b0, OS);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            if (hook == 1 && i == 4) begin
                wait_ticks(OS/2);
                reset = 1'b1;
                #1;
                check("midreset data", 32'(rx_data), 32'd0);
                check("midreset valid", 32'(rx_valid), 32'd0);
                check("midreset ferr", 32'(frame_err), 32'd0);
                check("midreset busy", 32'(busy), 32'd0);
                @(posedge clk);
                @(posedge clk);
                #1;
                reset     = 1'b0;
                rxd       = 1'b1;
                last_good = 8'h00;
                return;
            end else if (hook == 2 && i == 3) begin
                wait_ticks(OS/2);
                snap    = rx_data;
                tick_en = 1'b0;
                repeat (100) @(posedge clk);
                #1;
                check("pause busy", 32'(busy), 32'd1);
                check("pause data", 32'(rx_data), 32'(snap));
                tick_en = 1'b1;
                wait_ticks(OS/2);
            end else begin
                wait_ticks(OS);
            end
        end
        send_bit(stop, OS);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset data", 32'(rx_data), 32'd0);
        check("reset valid", 32'(rx_valid), 32'd0);
        check("reset ferr", 32'(frame_err), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        reset = 1'b0;
        wait_ticks(4);

        // Single frame.
        send_frame(8'hA5, 1'b1, 0);
        check("busy after A5", 32'(busy), 32'd0);
        send_bit(1'b1, 4);
        check("A5 received", 32'(exp_q.size()), 32'd0);

        // Back-to-back frames.
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        send_bit(1'b1, 4);
        check("b2b received", 32'(exp_q.size()), 32'd0);

        // Short low glitch is rejected.
        send_bit(1'b0, 3);
        send_bit(1'b1, OS);
        check("glitch idle", 32'(busy), 32'd0);
        send_frame(8'h3C, 1'b1, 0);
        send_bit(1'b1, 4);

        // Framing error then held-low line.
        send_frame(8'h55, 1'b0, 0);
        send_bit(1'b0, 40);
        check("break busy", 32'(busy), 32'd1);
        check("break data kept", 32'(rx_data), 32'h3C);
        send_bit(1'b1, 20);
        check("break released", 32'(busy), 32'd0);
        send_frame(8'h81, 1'b1, 0);
        send_bit(1'b1, 4);

        // Reset mid-frame, then a fresh frame.
        send_frame(8'hC3, 1'b1, 1);
        send_bit(1'b1, 20);
        check("post reset idle", 32'(busy), 32'd0);
        send_frame(8'h7E, 1'b1, 0);
        send_bit(1'b1, 4);

        // Tick paused mid-frame.
        send_frame(8'h96, 1'b1, 2);
        send_bit(1'b1, 20);

        check("all strobes seen", 32'(exp_q.size()), 32'd0);
        check("final data", 32'(rx_data), 32'h96);
        check("final busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
